// File: rtl/ins_loader.sv
// ins_loader: receives a little-endian byte stream and writes it as 32-bit
// words into instruction memory, holding the CPU program counter off while a
// load is in progress.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_start        one-cycle request to start a load (honoured in IDLE only)
//   load_len          word count, sampled with load_start
//   in_valid, in_data byte stream input, LSB of each word first
//   in_ready          byte accepted when in_valid && in_ready
//   wr_en/addr/data   instruction-memory write port
//   pc_write          CPU run enable (high in IDLE once a load has completed)
//   busy, done        load in progress / one-cycle completion pulse
//   checksum          mod-256 sum of bytes accepted in current or last load
module ins_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             pc_write,
    output logic             busy,
    output logic             done,
    output logic [7:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      asm_q, asm_d;
    logic             loaded_q, loaded_d;

    logic             in_ready_d, wr_en_d, pc_write_d, busy_d, done_d;
    logic [31:0]      wr_addr_d, wr_data_d;
    logic [7:0]       checksum_d;

    // Next-state and next-output logic; outputs are registered from the
    // next state so they line up exactly with the state they describe.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        loaded_d   = loaded_q;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        checksum_d = checksum;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    len_d      = load_len;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    asm_d      = '0;
                    checksum_d = '0;
                    state_d    = (load_len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    checksum_d = checksum + in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d   = WRITE;
                        wr_data_d = asm_d;
                        // Byte address wraps naturally at 32 bits.
                        wr_addr_d = BASE_ADDR + (32'(word_idx_q) << 2);
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + LEN_W'(1);
                state_d    = (word_idx_d == len_q) ? DONE : RECV;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            loaded_d = 1'b1;
        end

        in_ready_d = (state_d == RECV);
        wr_en_d    = (state_d == WRITE);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        pc_write_d = (state_d == IDLE) && loaded_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            loaded_q   <= 1'b0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pc_write   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            loaded_q   <= loaded_d;
            in_ready   <= in_ready_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            pc_write   <= pc_write_d;
            busy       <= busy_d;
            done       <= done_d;
            checksum   <= checksum_d;
        end
    end

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: two instances (base 0 and base 0xFFFFFFFC) share the
// same stimulus; a byte-list reference model predicts writes and checksum.
module tb_ins_loader;

    localparam int unsigned LEN_W = 16;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_start;
    logic [LEN_W-1:0] load_len;
    logic             in_valid;
    logic [7:0]       in_data;

    logic        in_ready0, wr_en0, pc_write0, busy0, done0;
    logic [31:0] wr_addr0, wr_data0;
    logic [7:0]  checksum0;
    logic        in_ready1, wr_en1, pc_write1, busy1, done1;
    logic [31:0] wr_addr1, wr_data1;
    logic [7:0]  checksum1;

    ins_loader #(.BASE_ADDR(BASE0), .LEN_W(LEN_W)) dut0 (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .pc_write(pc_write0), .busy(busy0), .done(done0), .checksum(checksum0)
    );

    ins_loader #(.BASE_ADDR(BASE1), .LEN_W(LEN_W)) dut1 (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .pc_write(pc_write1), .busy(busy1), .done(done1), .checksum(checksum1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] got0[$];
    logic [63:0] got1[$];
    logic [7:0]  stim[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture every write strobe; in_ready must be low during any write.
    always @(negedge clk) begin
        if (wr_en0 === 1'b1) begin
            got0.push_back({wr_addr0, wr_data0});
            chk("ready_in_write0", 64'(in_ready0), 64'd0);
        end
        if (wr_en1 === 1'b1) begin
            got1.push_back({wr_addr1, wr_data1});
            chk("ready_in_write1", 64'(in_ready1), 64'd0);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out0"}, {in_ready0, wr_en0, busy0, done0, pc_write0, checksum0},
            64'd0);
        chk({tag, "_out1"}, {in_ready1, wr_en1, busy1, done1, pc_write1, checksum1},
            64'd0);
        chk({tag, "_wr0"}, {wr_addr0, wr_data0}, 64'd0);
        chk({tag, "_wr1"}, {wr_addr1, wr_data1}, 64'd0);
    endtask

    task automatic fill_random(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    // Run one complete load of n words from stim[], with optional random
    // in_valid gaps and an optional extra load_start injected mid-load.
    task automatic run_load(input int n, input bit gaps, input bit intrude);
        logic [63:0] exp0[$];
        logic [63:0] exp1[$];
        logic [7:0]  cs;
        int          b;
        int          guard;
        int          w;
        bit          acc;

        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] word;
            word = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            exp0.push_back({BASE0 + 32'(4 * i), word});
            exp1.push_back({BASE1 + 32'(4 * i), word});
        end
        for (int i = 0; i < 4 * n; i++) cs = cs + stim[i];

        got0.delete();
        got1.delete();
        @(negedge clk);
        load_start = 1'b1;
        load_len   = LEN_W'(n);
        @(negedge clk);
        load_start = 1'b0;

        b     = 0;
        guard = 0;
        while (b < 4 * n && guard < 4000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stim[b];
            if (intrude && b == 5) begin
                load_start = 1'b1;
                load_len   = LEN_W'(7);
            end
            acc = in_valid && in_ready0;
            @(negedge clk);
            load_start = 1'b0;
            if (acc) b++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 4000) chk("byte_timeout", 64'(b), 64'(4 * n));

        w = 0;
        while (done0 !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", 64'(done0), 64'd1);
        if (n == 0) chk("done_latency_len0", 64'(w), 64'd0);
        chk("done1", 64'(done1), 64'd1);
        chk("busy_in_done", {busy0, busy1, pc_write0, pc_write1}, 64'b1100);
        chk("checksum0", 64'(checksum0), 64'(cs));
        chk("checksum1", 64'(checksum1), 64'(cs));

        @(negedge clk);
        chk("after_done", {done0, done1, busy0, busy1, pc_write0, pc_write1}, 64'b000011);
        chk("checksum_hold", 64'(checksum0), 64'(cs));

        chk("wr_count0", 64'(got0.size()), 64'(n));
        chk("wr_count1", 64'(got1.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got0.size()) chk($sformatf("write0_%0d", i), got0[i], exp0[i]);
            if (i < got1.size()) chk($sformatf("write1_%0d", i), got1[i], exp1[i]);
        end
    endtask

    initial begin
        int b;
        bit acc;

        rst        = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("pc_write_never_loaded", {pc_write0, pc_write1}, 64'd0);

        // Two-word program, stream without gaps.
        stim.delete();
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, 1'b0, 1'b0);
        chk("prog_checksum", 64'(checksum0), 64'hB6);
        if (got0.size() == 2) begin
            chk("prog_w0", got0[0], {32'h0000_0000, 32'h0000_0013});
            chk("prog_w1", got0[1], {32'h0000_0004, 32'h0010_0093});
        end
        if (got1.size() == 2) begin
            chk("prog_wrap_w0", got1[0], {32'hFFFF_FFFC, 32'h0000_0013});
            chk("prog_wrap_w1", got1[1], {32'h0000_0000, 32'h0010_0093});
        end

        // Three words with random gaps, then the same bytes gap-free.
        fill_random(12);
        run_load(3, 1'b1, 1'b0);
        run_load(3, 1'b0, 1'b0);

        // Zero-length load.
        run_load(0, 1'b0, 1'b0);

        // Extra load_start while busy must be ignored.
        fill_random(12);
        run_load(3, 1'b1, 1'b1);

        // Reset after six bytes of a four-word load.
        fill_random(16);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = LEN_W'(4);
        @(negedge clk);
        load_start = 1'b0;
        b = 0;
        for (int g = 0; g < 100 && b < 6; g++) begin
            in_valid = 1'b1;
            in_data  = stim[b];
            acc = in_ready0;
            @(negedge clk);
            if (acc) b++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("mid_reset");
        got0.delete();
        got1.delete();
        repeat (6) @(negedge clk);
        chk("no_write_after_reset", 64'(got0.size() + got1.size()), 64'd0);
        chk("pc_write_after_reset", {pc_write0, pc_write1, busy0}, 64'd0);
        fill_random(4);
        run_load(1, 1'b0, 1'b0);

        // A few random loads of varied length.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 5);
            fill_random(4 * n);
            run_load(n, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
